// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
// Holds the default widths, the port identifier and the read-tag layout.
package dmem_pkg;

    localparam int DMEM_ADDR_WIDTH = 8;
    localparam int DMEM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_A    = 2'd1,
        PORT_B    = 2'd2
    } port_t;

    typedef struct packed {
        logic a_rd;
        logic b_rd;
    } rd_tag_t;

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating count of consecutive cycles port B was denied.
// Raises force_grant once the count reaches MAX_WAIT while B is still requesting.
module dmem_starve_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic force_grant
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (!req || gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // The forced grant clears the count, so force lasts exactly one cycle.
    assign force_grant = req && (wait_cnt == MAX_CNT) && !reset;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU has priority,
// the debug/DMA port is forced through after MAX_WAIT consecutive denials.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_stall,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    port_t   sel;
    logic    sel_a;
    logic    sel_b;
    logic    force_b;
    rd_tag_t tag;
    rd_tag_t tag_next;

    dmem_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clock       (clock),
        .reset       (reset),
        .req         (b_req),
        .gnt         (sel_b),
        .force_grant (force_b)
    );

    always_comb begin
        sel = PORT_NONE;
        if (force_b) begin
            sel = PORT_B;
        end else if (a_req) begin
            sel = PORT_A;
        end else if (b_req) begin
            sel = PORT_B;
        end
    end

    assign sel_a   = (sel == PORT_A);
    assign sel_b   = (sel == PORT_B);
    assign a_stall = a_req && force_b;
    assign b_gnt   = sel_b;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (sel)
            PORT_A: begin
                mem_en    = 1'b1;
                mem_we    = a_we;
                mem_addr  = a_addr;
                mem_wdata = a_wdata;
            end
            PORT_B: begin
                mem_en    = 1'b1;
                mem_we    = b_we;
                mem_addr  = b_addr;
                mem_wdata = b_wdata;
            end
            default: ;
        endcase
    end

    // Remember which port owns the read data arriving next cycle.
    always_comb begin
        tag_next.a_rd = sel_a && !a_we;
        tag_next.b_rd = sel_b && !b_we;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag <= '0;
        end else begin
            tag <= tag_next;
        end
    end

    assign a_rvalid = tag.a_rd;
    assign b_rvalid = tag.b_rd;
    assign a_rdata  = mem_rdata;
    assign b_rdata  = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline memory stage (port A, CPU) and a debug/DMA loader (port B).
- Fixed priority to the CPU, with a bounded-starvation override for port B.
- Stalls the pipeline when it loses a cycle, and tags one-cycle-latency read data back to the owning port.
- Sits between the memory-stage logic and the data memory instance.

Parameters:
ADDR_WIDTH, 8, word address width into data memory
DATA_WIDTH, 32, data word width
MAX_WAIT, 4, consecutive denied cycles after which port B is forced a grant (range 1..15)

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
a_req  in  1  CPU memory access request, valid this cycle
a_we  in  1  CPU write enable (1 = store, 0 = load)
a_addr  in  ADDR_WIDTH  CPU word address
a_wdata  in  DATA_WIDTH  CPU store data
a_stall  out  1  CPU request not serviced this cycle; pipeline must hold
a_rvalid  out  1  a_rdata holds data for the CPU load granted last cycle
a_rdata  out  DATA_WIDTH  read data for port A
b_req  in  1  debug/DMA request
b_we  in  1  port B write enable
b_addr  in  ADDR_WIDTH  port B address
b_wdata  in  DATA_WIDTH  port B write data
b_gnt  out  1  port B request accepted this cycle
b_rvalid  out  1  b_rdata holds data for the port B read granted last cycle
b_rdata  out  DATA_WIDTH  read data for port B
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid one clock after a granted read

Behaviour:
- Grant is decided combinationally each cycle. force_b = b_req && (wait_cnt == MAX_WAIT).
  - sel_b = force_b || (b_req && !a_req).
  - sel_a = a_req && !force_b.
- a_stall = a_req && force_b.
- b_gnt = sel_b.
- Memory outputs come from the selected port.
  - mem_en = sel_a || sel_b.
  - With no grant: mem_we = 0; mem_addr and mem_wdata hold 0.
- Write is committed on the granting edge. A write produces no rvalid.
- Read tag register (2 bits, {a, b}) captures (sel_x && !x_we) on each rising edge.
  - a_rvalid and b_rvalid are driven from the tag register.
  - a_rdata = b_rdata = mem_rdata, unmasked. Consumers qualify with rvalid.
  - Read latency is exactly 1 cycle. Back-to-back reads from either port are permitted every cycle.
- wait_cnt (4 bits):
  - Increments when b_req && !sel_b.
  - Clears to 0 when sel_b or !b_req.
  - Saturates at MAX_WAIT. It never exceeds MAX_WAIT, so force_b lasts exactly one grant.
- A CPU that is stalled holds a_req, a_we, a_addr and a_wdata stable. It is serviced the next cycle because wait_cnt is then 0.
- b_req may drop without a grant: the counter clears and there is no side effect.
- Reset (asynchronous, any time):
  - wait_cnt = 0 and the tag register = 0, so a_rvalid = 0 and b_rvalid = 0.
  - A read granted in the cycle reset asserts is discarded.
  - Combinational outputs follow the inputs while in reset, except that force_b = 0.
- Simultaneous a_req and b_req with wait_cnt < MAX_WAIT: A wins, B is denied, and the counter increments.
- Only one memory access occurs per cycle. Data hazards between A and B writes are not checked; software owns coherence.

Decomposition:
- Package dmem_pkg holds:
  - DMEM_ADDR_WIDTH and DMEM_DATA_WIDTH constants.
  - The port-id enum (PORT_NONE, PORT_A, PORT_B).
  - The read-tag struct {a_rd, b_rd}.
- Sub-module dmem_starve_counter holds the saturating wait counter.
  - Inputs: clock, reset, req, gnt.
  - Output: force.
  - Parameter: MAX_WAIT.
- The arbiter top holds the grant mux and the tag register.

Test Plan:
- A read, addr 8'h10, b_req = 0; memory word holds 32'hDEADBEEF -> mem_en = 1, a_stall = 0; next cycle a_rvalid = 1, a_rdata = 32'hDEADBEEF, b_rvalid = 0.
- B write, addr 8'h20, data 32'h12345678, a_req = 0 -> b_gnt = 1, mem_we = 1, mem_addr = 8'h20; a later A read of 8'h20 returns 32'h12345678 with a_rvalid one cycle after its grant.
- Continuous a_req and b_req with MAX_WAIT = 4:
  - b_gnt = 0 for 4 cycles, then b_gnt = 1 with a_stall = 1 on cycle 5.
  - Cycle 6: a_stall = 0; A is serviced and the counter restarts.
  - The pattern repeats with period 5.
- Alternating reads A, B, A, B every cycle, with no simultaneous requests -> no stall; a_rvalid and b_rvalid each pulse one cycle after their own grant; tags are never crossed.
- b_req asserted 2 cycles under A contention, then dropped -> wait_cnt returns to 0; a later B request needs 4 fresh denials before it is forced.
- Reset pulsed mid-cycle right after a granted A read -> a_rvalid = 0 immediately and stays 0 after release; wait_cnt = 0.
